mem_stall_unit: RTL and testbench

MEM_STALL_UNIT -- requirements
Module: mem_stall_unit

---
 rtl/mem_stall_unit.sv | 219 +++++++++++++++++++++
 tb/tb_mem_stall_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stall_unit.sv
// -----------------------------------------------------------------------------
// mem_stall_unit
//
// Arbitrates a single physical memory port between the instruction fetch (IF)
// and data access (MEM) stages of a pipeline. Stall outputs are held high until
// the matching access has completed. Both done flags are cleared on the edge
// where the pipeline advances.
//
// Optional feature (macro MEM_STALL_PERF_CNT_EN):
//   Adds free-running 32-bit stall-cycle counters istall_count and
//   dstall_count. When the macro is undefined, the counters and their ports
//   do not exist.
//
// Ports:
//   clk               in   single clock; all state changes on its rising edge
//   rst               in   synchronous active-high reset
//   if_read           in   IF stage fetch request
//   if_addr    [31:0] in   fetch address
//   if_rdata   [31:0] out  fetched instruction, held until the next capture
//   mem_read          in   MEM stage load request
//   mem_write         in   MEM stage store request
//   mem_addr   [31:0] in   data address
//   mem_wdata  [31:0] in   store data
//   mem_byte_en [3:0] in   store byte enables
//   mem_rdata  [31:0] out  loaded word, held until the next capture
//   pmem_read         out  physical memory read command
//   pmem_write        out  physical memory write command
//   pmem_addr  [31:0] out  physical memory address
//   pmem_wdata [31:0] out  physical memory write data
//   pmem_byte_en [3:0] out physical memory byte enables
//   pmem_rdata [31:0] in   physical memory read data
//   pmem_resp         in   single-cycle completion pulse
//   read_intr_stall   out  instruction fetch outstanding
//   mem_access_stall  out  data access outstanding
//   istall_count [31:0] out  (macro only) cycles with read_intr_stall high
//   dstall_count [31:0] out  (macro only) cycles with mem_access_stall high
//
// States:
//   IDLE    | no memory command issued; pmem_resp ignored
//   DACCESS | data access issued from the mem_* inputs
//   IFETCH  | instruction fetch issued from if_addr
// -----------------------------------------------------------------------------
module mem_stall_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_read,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byte_en,
  output logic [31:0] mem_rdata,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_addr,
  output logic [31:0] pmem_wdata,
  output logic [3:0]  pmem_byte_en,
  input  logic [31:0] pmem_rdata,
  input  logic        pmem_resp,
  output logic        read_intr_stall,
  output logic        mem_access_stall
`ifdef MEM_STALL_PERF_CNT_EN
  ,
  output logic [31:0] istall_count,
  output logic [31:0] dstall_count
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DACCESS = 2'd1,
    IFETCH  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic i_done;
  logic d_done;
  logic i_pend;
  logic d_pend;
  logic pipe_advance;
  logic i_capture;
  logic d_capture;

  // A request is pending until its done flag is set; the flags then mask the
  // still-held request inputs until the pipeline advances.
  assign i_pend = if_read & ~i_done;
  assign d_pend = (mem_read | mem_write) & ~d_done;

  assign read_intr_stall  = i_pend;
  assign mem_access_stall = d_pend;

  // No stall in this cycle means the pipeline moves on at the next edge and
  // presents fresh requests, so the done flags must not carry over.
  assign pipe_advance = ~i_pend & ~d_pend;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and memory command decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_addr    = 32'h0;
    pmem_wdata   = 32'h0;
    pmem_byte_en = 4'h0;
    i_capture    = 1'b0;
    d_capture    = 1'b0;

    unique case (state)
      IDLE: begin
        // Data access wins over fetch so the older instruction completes first.
        if (d_pend) begin
          state_nxt = DACCESS;
        end else if (i_pend) begin
          state_nxt = IFETCH;
        end
      end

      DACCESS: begin
        pmem_read    = mem_read;
        pmem_write   = mem_write;
        pmem_addr    = mem_addr;
        pmem_wdata   = mem_wdata;
        pmem_byte_en = mem_byte_en;
        if (pmem_resp) begin
          d_capture = 1'b1;
          state_nxt = i_pend ? IFETCH : IDLE;
        end
      end

      IFETCH: begin
        pmem_read    = 1'b1;
        pmem_addr    = if_addr;
        pmem_byte_en = 4'hF;
        if (pmem_resp) begin
          i_capture = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Done flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else if (pipe_advance) begin
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else begin
      if (i_capture) begin
        i_done <= 1'b1;
      end
      if (d_capture) begin
        d_done <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read data holding registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata  <= 32'h0;
      mem_rdata <= 32'h0;
    end else begin
      if (i_capture) begin
        if_rdata <= pmem_rdata;
      end
      // A store completion returns no meaningful data; keep the last load.
      if (d_capture && mem_read) begin
        mem_rdata <= pmem_rdata;
      end
    end
  end

`ifdef MEM_STALL_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Stall-cycle counters; wrap naturally at 2^32
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      istall_count <= 32'h0;
      dstall_count <= 32'h0;
    end else begin
      if (read_intr_stall) begin
        istall_count <= istall_count + 32'd1;
      end
      if (mem_access_stall) begin
        dstall_count <= dstall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_stall_unit.sv
module tb_mem_stall_unit;

  logic        clk;
  logic        rst;
  logic        if_read;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_rdata;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_addr;
  logic [31:0] pmem_wdata;
  logic [3:0]  pmem_byte_en;
  logic [31:0] pmem_rdata;
  logic        pmem_resp;
  logic        read_intr_stall;
  logic        mem_access_stall;
`ifdef MEM_STALL_PERF_CNT_EN
  logic [31:0] istall_count;
  logic [31:0] dstall_count;
`endif

  int checks;
  int failures;

  mem_stall_unit dut (
    .clk              (clk),
    .rst              (rst),
    .if_read          (if_read),
    .if_addr          (if_addr),
    .if_rdata         (if_rdata),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_byte_en      (mem_byte_en),
    .mem_rdata        (mem_rdata),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_addr        (pmem_addr),
    .pmem_wdata       (pmem_wdata),
    .pmem_byte_en     (pmem_byte_en),
    .pmem_rdata       (pmem_rdata),
    .pmem_resp        (pmem_resp),
    .read_intr_stall  (read_intr_stall),
    .mem_access_stall (mem_access_stall)
`ifdef MEM_STALL_PERF_CNT_EN
    ,
    .istall_count     (istall_count),
    .dstall_count     (dstall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    if_read     = 1'b0;
    if_addr     = 32'h0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = 32'h0;
    mem_wdata   = 32'h0;
    mem_byte_en = 4'h0;
    pmem_rdata  = 32'h0;
    pmem_resp   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_istall", read_intr_stall, 1'b0);
    chk("rst_dstall", mem_access_stall, 1'b0);
    chk("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    tick();

    // Fetch only, zero wait states.
    if_read = 1'b1;
    if_addr = 32'h60;
    #1;
    chk("f_idle_istall", read_intr_stall, 1'b1);
    chk("f_idle_pmem_read", pmem_read, 1'b0);
    tick();
    pmem_resp  = 1'b1;
    pmem_rdata = 32'h00A00093;
    #1;
    chk("f_ifetch_istall", read_intr_stall, 1'b1);
    chk("f_ifetch_pmem_read", pmem_read, 1'b1);
    chk("f_ifetch_pmem_write", pmem_write, 1'b0);
    chk("f_ifetch_pmem_addr", pmem_addr, 32'h60);
    chk("f_ifetch_byte_en", pmem_byte_en, 4'hF);
    tick();
    pmem_resp = 1'b0;
    #1;
    chk("f_done_istall", read_intr_stall, 1'b0);
    chk("f_done_if_rdata", if_rdata, 32'h00A00093);
    chk("f_done_pmem_read", pmem_read, 1'b0);
    tick();
    if_read = 1'b0;
    #1;
    chk("f_after_if_rdata_hold", if_rdata, 32'h00A00093);

    // Reset so the optional counters start from zero for the next scenario.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_if_rdata", if_rdata, 32'h0);

    // Simultaneous fetch and load, two-cycle memory latency.
    if_read  = 1'b1;
    if_addr  = 32'h64;
    mem_read = 1'b1;
    mem_addr = 32'h100;
    #1;
    chk("s_c0_istall", read_intr_stall, 1'b1);
    chk("s_c0_dstall", mem_access_stall, 1'b1);
    chk("s_c0_pmem_read", pmem_read, 1'b0);
    tick();
    chk("s_c1_pmem_read", pmem_read, 1'b1);
    chk("s_c1_pmem_write", pmem_write, 1'b0);
    chk("s_c1_pmem_addr", pmem_addr, 32'h100);
    tick();
    pmem_resp  = 1'b1;
    pmem_rdata = 32'h12345678;
    #1;
    chk("s_c2_pmem_addr", pmem_addr, 32'h100);
    chk("s_c2_dstall", mem_access_stall, 1'b1);
    tick();
    pmem_resp = 1'b0;
    #1;
    chk("s_c3_dstall", mem_access_stall, 1'b0);
    chk("s_c3_istall", read_intr_stall, 1'b1);
    chk("s_c3_pmem_addr", pmem_addr, 32'h64);
    chk("s_c3_byte_en", pmem_byte_en, 4'hF);
    chk("s_c3_mem_rdata", mem_rdata, 32'h12345678);
    tick();
    pmem_resp  = 1'b1;
    pmem_rdata = 32'hCAFEF00D;
    #1;
    chk("s_c4_pmem_read", pmem_read, 1'b1);
    tick();
    pmem_resp = 1'b0;
    #1;
    chk("s_c5_istall", read_intr_stall, 1'b0);
    chk("s_c5_dstall", mem_access_stall, 1'b0);
    chk("s_c5_if_rdata", if_rdata, 32'hCAFEF00D);
    chk("s_c5_pmem_read", pmem_read, 1'b0);
    tick();
    // Flags cleared on the advance edge: held requests stall again.
    chk("s_c6_istall_clr", read_intr_stall, 1'b1);
    chk("s_c6_dstall_clr", mem_access_stall, 1'b1);
    if_read  = 1'b0;
    mem_read = 1'b0;
    #1;
    chk("s_c6_istall_drop", read_intr_stall, 1'b0);
    tick();
`ifdef MEM_STALL_PERF_CNT_EN
    chk("s_istall_count", istall_count, 32'd5);
    chk("s_dstall_count", dstall_count, 32'd3);
`endif
    chk("s_c7_pmem_read", pmem_read, 1'b0);

    // Store path.
    mem_write   = 1'b1;
    mem_addr    = 32'h200;
    mem_wdata   = 32'hDEADBEEF;
    mem_byte_en = 4'b0011;
    #1;
    chk("w_c0_dstall", mem_access_stall, 1'b1);
    tick();
    pmem_resp  = 1'b1;
    pmem_rdata = 32'h55555555;
    #1;
    chk("w_c1_pmem_write", pmem_write, 1'b1);
    chk("w_c1_pmem_read", pmem_read, 1'b0);
    chk("w_c1_pmem_addr", pmem_addr, 32'h200);
    chk("w_c1_pmem_wdata", pmem_wdata, 32'hDEADBEEF);
    chk("w_c1_byte_en", pmem_byte_en, 4'b0011);
    tick();
    pmem_resp = 1'b0;
    #1;
    chk("w_c2_dstall", mem_access_stall, 1'b0);
    chk("w_c2_mem_rdata", mem_rdata, 32'h12345678);
    chk("w_c2_pmem_write", pmem_write, 1'b0);
    tick();
    mem_write = 1'b0;
    #1;

    // Reset in the second DACCESS cycle, late response afterwards.
    mem_read = 1'b1;
    mem_addr = 32'h300;
    tick();
    chk("r_c1_pmem_read", pmem_read, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    chk("r_c2_pmem_read", pmem_read, 1'b1);
    tick();
    rst        = 1'b0;
    mem_read   = 1'b0;
    pmem_resp  = 1'b1;
    pmem_rdata = 32'h99999999;
    #1;
    chk("r_c3_pmem_read", pmem_read, 1'b0);
    chk("r_c3_mem_rdata", mem_rdata, 32'h0);
    tick();
    pmem_resp = 1'b0;
    #1;
    chk("r_c4_mem_rdata", mem_rdata, 32'h0);
    chk("r_c4_pmem_read", pmem_read, 1'b0);
    chk("r_c4_dstall", mem_access_stall, 1'b0);

    // Stray response while idle.
    pmem_resp  = 1'b1;
    pmem_rdata = 32'hFFFFFFFF;
    #1;
    chk("i_c0_istall", read_intr_stall, 1'b0);
    chk("i_c0_dstall", mem_access_stall, 1'b0);
    tick();
    pmem_resp = 1'b0;
    #1;
    chk("i_c1_pmem_read", pmem_read, 1'b0);
    chk("i_c1_if_rdata", if_rdata, 32'h0);
    chk("i_c1_mem_rdata", mem_rdata, 32'h0);
    chk("i_c1_istall", read_intr_stall, 1'b0);
    chk("i_c1_dstall", mem_access_stall, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
